// File: rtl/dircc_counter_receive_arbiter.sv
// Receive arbiter for a DIRCC counter device.
// Picks one pending receive channel round-robin, adds its increment to the
// count held in the caller's user state, and commits the new state with a
// one-cycle strobe. It also flags the device DONE|STOPPED when the count
// reaches max_time.
// Optional feature macro: DIRCC_COUNTER_SATURATE_EN. When it is defined, the
// count addition saturates. When it is undefined, the count addition wraps.
// Handshake: packet_in_valid[i] is a request that the caller holds until
// packet_handled[i] pulses. The channel counts as consumed in that pulse
// cycle, so it is masked from arbitration during that cycle. Deasserting
// valid after a grant does not cancel the transaction.
module dircc_counter_receive_arbiter #(
  parameter int          NUM_CHANNELS        = 4,
  parameter int          COUNT_WIDTH         = 16,
  parameter int          STATE_WIDTH         = 64,
  parameter logic [7:0]  DIRCC_STATE_DONE    = 8'h01,
  parameter logic [7:0]  DIRCC_STATE_STOPPED = 8'h02
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [COUNT_WIDTH-1:0]            max_time,
  input  logic [NUM_CHANNELS-1:0]           packet_in_valid,
  input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] packet_in_inc,
  output logic [NUM_CHANNELS-1:0]           packet_handled,
  input  logic [STATE_WIDTH-1:0]            read_user_state,
  input  logic [7:0]                        read_dircc_state,
  output logic [STATE_WIDTH-1:0]            write_user_state,
  output logic [7:0]                        write_dircc_state,
  output logic                              write_state_valid,
  output logic                              busy,
  output logic [1:0]                        o_dbg_state
);

  localparam int IDXW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t                   r_state, w_state_next;
  logic [IDXW-1:0]          r_rr_ptr;
  logic [IDXW-1:0]          r_grant;
  logic [COUNT_WIDTH-1:0]   r_inc;
  logic [STATE_WIDTH-1:0]   r_pend_user;
  logic [7:0]               r_pend_dircc;
  logic                     r_pend_skip;

  logic [NUM_CHANNELS-1:0]  w_req;
  logic                     w_found;
  logic [IDXW-1:0]          w_grant;
  logic [IDXW-1:0]          w_rr_next;
  logic                     w_grant_en;
  logic                     w_update_en;
  logic                     w_write_en;
  logic [COUNT_WIDTH:0]     w_sum;
  logic [COUNT_WIDTH-1:0]   w_new_count;
  logic                     w_done;
  logic                     w_stopped;
  logic [STATE_WIDTH-1:0]   w_new_user;
  logic [7:0]               w_new_dircc;
  logic [NUM_CHANNELS-1:0]  w_grant_onehot;

  // Round-robin search: start at r_rr_ptr, first requesting channel wins.
  always_comb begin
    logic [IDXW:0] idx;
    w_req   = packet_in_valid & ~packet_handled;
    w_found = 1'b0;
    w_grant = '0;
    idx     = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx = {1'b0, r_rr_ptr} + (IDXW+1)'(i);
      if (idx >= (IDXW+1)'(NUM_CHANNELS)) idx = idx - (IDXW+1)'(NUM_CHANNELS);
      if (!w_found && w_req[idx[IDXW-1:0]]) begin
        w_found = 1'b1;
        w_grant = idx[IDXW-1:0];
      end
    end
    if (w_grant == IDXW'(NUM_CHANNELS - 1)) w_rr_next = '0;
    else                                    w_rr_next = w_grant + IDXW'(1);
  end

  // FSM next-state logic and per-state enables.
  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    w_update_en  = 1'b0;
    w_write_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_en   = 1'b1;
          w_state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_update_en  = 1'b1;
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        w_write_en   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // New count and device state, built from the read-back state during UPDATE.
  always_comb begin
    w_sum = {1'b0, read_user_state[COUNT_WIDTH-1:0]} + {1'b0, r_inc};
`ifdef DIRCC_COUNTER_SATURATE_EN
    w_new_count = w_sum[COUNT_WIDTH] ? '1 : w_sum[COUNT_WIDTH-1:0];
`else
    w_new_count = w_sum[COUNT_WIDTH-1:0];
`endif
    w_done    = (w_new_count >= max_time);
    w_stopped = ((read_dircc_state & DIRCC_STATE_STOPPED) != 8'd0);
    w_new_user = read_user_state;
    w_new_user[COUNT_WIDTH-1:0] = w_new_count;
    w_new_user[COUNT_WIDTH+15:COUNT_WIDTH] = w_done ? 16'd0 : 16'd1;
    w_new_dircc = w_done ? (read_dircc_state | DIRCC_STATE_DONE | DIRCC_STATE_STOPPED)
                         : read_dircc_state;
    w_grant_onehot = '0;
    w_grant_onehot[r_grant] = 1'b1;
  end

  // Grant capture, pending result, and output strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr          <= '0;
      r_grant           <= '0;
      r_inc             <= '0;
      r_pend_user       <= '0;
      r_pend_dircc      <= '0;
      r_pend_skip       <= 1'b0;
      packet_handled    <= '0;
      write_state_valid <= 1'b0;
      write_user_state  <= '0;
      write_dircc_state <= '0;
    end else begin
      packet_handled    <= '0;
      write_state_valid <= 1'b0;
      if (w_grant_en) begin
        r_grant  <= w_grant;
        r_inc    <= packet_in_inc[w_grant*COUNT_WIDTH +: COUNT_WIDTH];
        r_rr_ptr <= w_rr_next;
      end
      if (w_update_en) begin
        r_pend_user  <= w_new_user;
        r_pend_dircc <= w_new_dircc;
        r_pend_skip  <= w_stopped;
      end
      if (w_write_en) begin
        packet_handled <= w_grant_onehot;
        if (!r_pend_skip) begin
          write_state_valid <= 1'b1;
          write_user_state  <= r_pend_user;
          write_dircc_state <= r_pend_dircc;
        end
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule
